// File: rtl/uart_ring_collector.sv
// Multi-channel UART store-and-forward hub: per-channel ring buffers in one shared single-port RAM.
// Optional macro COLLECTOR_OVERFLOW_DROP_EN: drop bytes into a full ring and flag sticky o_overflow.
module uart_ring_collector #(
    parameter int NCH        = 10,
    parameter int DEPTH_LOG2 = 10,
    parameter int DW         = 8,
    localparam int CH_W      = $clog2(NCH),
    localparam int ADDRW     = CH_W + DEPTH_LOG2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NCH-1:0]       i_rx_ready,
    input  logic [NCH*DW-1:0]    i_rx_data,
    output logic [NCH-1:0]       o_rx_read,
    input  logic [NCH-1:0]       i_tx_full,
    output logic [NCH-1:0]       o_tx_write,
    output logic [DW-1:0]        o_tx_data,
    output logic [ADDRW-1:0]     o_addr,
    output logic [DW-1:0]        o_wdata,
    input  logic [DW-1:0]        i_rdata,
    output logic                 o_we,
    output logic                 o_re,
    output logic [NCH-1:0]       o_empty,
    output logic [NCH-1:0]       o_full
`ifdef COLLECTOR_OVERFLOW_DROP_EN
    ,
    output logic [NCH-1:0]       o_overflow
`endif
);

    typedef enum logic {
        ST_ARB     = 1'b0,
        ST_RD_DATA = 1'b1
    } state_t;

    localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [CH_W-1:0]     CH_LAST  = CH_W'(NCH - 1);

    state_t                r_state;
    logic [CH_W-1:0]       r_rr;
    logic [CH_W-1:0]       r_rd_ch;
    logic                  r_phase;
    logic [DEPTH_LOG2-1:0] r_wptr  [NCH];
    logic [DEPTH_LOG2-1:0] r_rptr  [NCH];
    logic [DEPTH_LOG2:0]   r_count [NCH];

    logic [CH_W-1:0]       w_ch;
    logic [DEPTH_LOG2:0]   w_cnt;
    logic                  w_ring_full;
    logic                  w_arb;
    logic                  w_wr_req;
    logic                  w_rd_ok;
    logic                  w_sel_rd;
    logic                  w_sel_wr;
    logic                  w_store;

    assign w_ch        = r_rr;
    assign w_cnt       = r_count[w_ch];
    assign w_ring_full = (w_cnt == FULL_CNT);
    assign w_arb       = (r_state == ST_ARB) && !i_rst;

    // In drop mode a full ring still competes for the slot so the byte can be discarded.
`ifdef COLLECTOR_OVERFLOW_DROP_EN
    assign w_wr_req = i_rx_ready[w_ch];
`else
    assign w_wr_req = i_rx_ready[w_ch] && !w_ring_full;
`endif
    assign w_rd_ok  = (w_cnt != '0) && !i_tx_full[w_ch];
    assign w_sel_rd = w_arb && w_rd_ok && (!w_wr_req || r_phase);
    assign w_sel_wr = w_arb && w_wr_req && !w_sel_rd;
    assign w_store  = w_sel_wr && !w_ring_full;

    always_comb begin
        o_rx_read  = '0;
        o_tx_write = '0;
        o_tx_data  = '0;
        o_addr     = '0;
        o_wdata    = '0;
        o_we       = 1'b0;
        o_re       = 1'b0;
        if (w_sel_wr) begin
            o_rx_read[w_ch] = 1'b1;
            if (!w_ring_full) begin
                o_we    = 1'b1;
                o_addr  = {w_ch, r_wptr[w_ch]};
                o_wdata = i_rx_data[int'(w_ch) * DW +: DW];
            end
        end else if (w_sel_rd) begin
            o_re   = 1'b1;
            o_addr = {w_ch, r_rptr[w_ch]};
        end else if (!i_rst && r_state == ST_RD_DATA) begin
            o_tx_write[r_rd_ch] = 1'b1;
            o_tx_data           = i_rdata;
        end
    end

    always_comb begin
        o_empty = '0;
        o_full  = '0;
        for (int c = 0; c < NCH; c++) begin
            o_empty[c] = (r_count[c] == '0);
            o_full[c]  = (r_count[c] == FULL_CNT);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_ARB;
            r_rr    <= '0;
            r_rd_ch <= '0;
            r_phase <= 1'b0;
            for (int c = 0; c < NCH; c++) begin
                r_wptr[c]  <= '0;
                r_rptr[c]  <= '0;
                r_count[c] <= '0;
            end
        end else begin
            case (r_state)
                ST_ARB: begin
                    r_rr <= (r_rr == CH_LAST) ? '0 : r_rr + CH_W'(1);
                    if (w_wr_req && w_rd_ok) begin
                        r_phase <= ~r_phase;
                    end
                    if (w_store) begin
                        r_wptr[w_ch]  <= r_wptr[w_ch] + DEPTH_LOG2'(1);
                        r_count[w_ch] <= w_cnt + (DEPTH_LOG2 + 1)'(1);
                    end
                    // Pointer and count move at issue; the data returns next cycle.
                    if (w_sel_rd) begin
                        r_rptr[w_ch]  <= r_rptr[w_ch] + DEPTH_LOG2'(1);
                        r_count[w_ch] <= w_cnt - (DEPTH_LOG2 + 1)'(1);
                        r_rd_ch       <= w_ch;
                        r_state       <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    r_state <= ST_ARB;
                end
            endcase
        end
    end

`ifdef COLLECTOR_OVERFLOW_DROP_EN
    logic [NCH-1:0] r_overflow;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_overflow <= '0;
        end else if (w_sel_wr && w_ring_full) begin
            r_overflow[w_ch] <= 1'b1;
        end
    end

    assign o_overflow = r_overflow;
`endif

endmodule

// File: tb/tb_uart_ring_collector.sv
// Bench for uart_ring_collector: queue-based reference model checked every cycle plus directed scenarios.
module tb_uart_ring_collector;

    localparam int NCH   = 10;
    localparam int DL2   = 2;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int ADDRW = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NCH-1:0]    rx_ready = '0;
    logic [NCH*DW-1:0] rx_data  = '0;
    logic [NCH-1:0]    tx_full  = '0;
    logic [DW-1:0]     rdata    = '0;
    logic [NCH-1:0]    o_rx_read, o_tx_write, o_empty, o_full;
    logic [DW-1:0]     o_tx_data, o_wdata;
    logic [ADDRW-1:0]  o_addr;
    logic              o_we, o_re;
`ifdef COLLECTOR_OVERFLOW_DROP_EN
    logic [NCH-1:0]    o_overflow;
`endif

    uart_ring_collector #(.NCH(NCH), .DEPTH_LOG2(DL2), .DW(DW)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_rx_ready(rx_ready), .i_rx_data(rx_data), .o_rx_read(o_rx_read),
        .i_tx_full(tx_full), .o_tx_write(o_tx_write), .o_tx_data(o_tx_data),
        .o_addr(o_addr), .o_wdata(o_wdata), .i_rdata(rdata),
        .o_we(o_we), .o_re(o_re), .o_empty(o_empty), .o_full(o_full)
`ifdef COLLECTOR_OVERFLOW_DROP_EN
        , .o_overflow(o_overflow)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Environment: receiver byte queues, transmitter full flags, RAM.
    logic [7:0]     src [NCH][$];
    logic [NCH-1:0] txf = '0;
    logic [7:0]     mem [64];

    always @(posedge clk) begin
        if (o_we) mem[o_addr] <= o_wdata;
        if (o_re) rdata <= mem[o_addr];
    end

    // Reference model: ring contents as queues, plus scheduler position.
    logic [7:0]     ring [NCH][$];
    int             pushes [NCH];
    int             pops [NCH];
    int             m_rr = 0;
    bit             m_phase = 0;
    bit             m_inrd = 0;
    int             m_rdch = 0;
    logic [7:0]     m_rdbyte = '0;
    logic [NCH-1:0] m_ovf = '0;

    // Observed event logs for directed literal checks.
    logic [15:0] wr_log [$];
    logic [15:0] tx_log [$];
    logic [7:0]  rd_log [$];
    bit          op_log [$];
    int          rxrd_cnt [NCH];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_inputs();
        for (int k = 0; k < NCH; k++) begin
            rx_ready[k]          = (src[k].size() > 0);
            rx_data[k*DW +: DW]  = (src[k].size() > 0) ? src[k][0] : 8'h00;
        end
        tx_full = txf;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            apply_inputs();
        end
    endtask

    task automatic clear_logs();
        wr_log.delete();
        tx_log.delete();
        rd_log.delete();
        op_log.delete();
        for (int k = 0; k < NCH; k++) rxrd_cnt[k] = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int k = 0; k < NCH; k++) src[k].delete();
        txf = '0;
        apply_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Per-cycle compare against the model, then advance the model as the clock edge would.
    logic [NCH-1:0] e_rxr, e_txw, e_empty, e_full;
    logic [7:0]     e_txd, e_wd;
    logic [5:0]     e_addr;
    logic           e_we, e_re;
    int             c, sz;
    bit             wr_c, rd_c, do_rd, do_wr;

    always @(negedge clk) begin
        e_rxr = '0; e_txw = '0; e_txd = '0; e_wd = '0; e_addr = '0; e_we = 0; e_re = 0;
        wr_c = 0; rd_c = 0; do_rd = 0; do_wr = 0; c = m_rr; sz = 0;
        for (int k = 0; k < NCH; k++) begin
            e_empty[k] = (ring[k].size() == 0);
            e_full[k]  = (ring[k].size() == DEPTH);
        end
        if (rst) begin
            e_empty = '1;
            e_full  = '0;
            m_ovf   = '0;
        end else if (m_inrd) begin
            e_txw[m_rdch] = 1'b1;
            e_txd = m_rdbyte;
        end else begin
            sz = ring[c].size();
`ifdef COLLECTOR_OVERFLOW_DROP_EN
            wr_c = rx_ready[c];
`else
            wr_c = rx_ready[c] && (sz < DEPTH);
`endif
            rd_c  = (sz > 0) && !tx_full[c];
            do_rd = rd_c && (!wr_c || m_phase);
            do_wr = wr_c && !do_rd;
            if (do_wr) begin
                e_rxr[c] = 1'b1;
                if (sz < DEPTH) begin
                    e_we   = 1'b1;
                    e_addr = 6'(c * DEPTH + pushes[c] % DEPTH);
                    e_wd   = rx_data[c*DW +: DW];
                end
            end else if (do_rd) begin
                e_re   = 1'b1;
                e_addr = 6'(c * DEPTH + pops[c] % DEPTH);
            end
        end
        check("cycle", {o_rx_read, o_tx_write, o_tx_data, o_addr, o_wdata, o_we, o_re, o_empty, o_full},
                       {e_rxr, e_txw, e_txd, e_addr, e_wd, e_we, e_re, e_empty, e_full});
`ifdef COLLECTOR_OVERFLOW_DROP_EN
        check("overflow", o_overflow, m_ovf);
`endif
        if (o_we) wr_log.push_back({2'b00, o_addr, o_wdata});
        if (o_re) rd_log.push_back({2'b00, o_addr});
        if ((o_we || o_re) && o_addr[5:2] == 4'd2) op_log.push_back(o_re);
        for (int k = 0; k < NCH; k++) begin
            if (o_tx_write[k]) tx_log.push_back({8'(k), o_tx_data});
            if (o_rx_read[k]) begin
                rxrd_cnt[k]++;
                if (src[k].size() > 0) void'(src[k].pop_front());
            end
        end
        if (rst) begin
            for (int k = 0; k < NCH; k++) begin
                ring[k].delete();
                pushes[k] = 0;
                pops[k]   = 0;
            end
            m_rr = 0; m_phase = 0; m_inrd = 0;
        end else if (m_inrd) begin
            m_inrd = 0;
        end else begin
            if (wr_c && rd_c) m_phase = !m_phase;
            if (do_wr) begin
                if (sz < DEPTH) begin
                    ring[c].push_back(rx_data[c*DW +: DW]);
                    pushes[c]++;
                end else begin
                    m_ovf[c] = 1'b1;
                end
            end
            if (do_rd) begin
                m_rdbyte = ring[c].pop_front();
                pops[c]++;
                m_inrd = 1;
                m_rdch = c;
            end
            m_rr = (m_rr + 1) % NCH;
        end
    end

    bit         found;
    int         t3_wr, t3_rxrd, t3_left, t3_tx;
    bit [9:0]   pat;
    logic [5:0] t4_addr [6];

    initial begin
        apply_inputs();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("init_empty", o_empty, 10'h3FF);
        check("init_full", o_full, 10'h000);

        // Reset asserted while a read is in its data cycle.
        for (int k = 0; k < 3; k++) begin
            src[k].push_back(8'(8'h50 + k));
            src[k].push_back(8'(8'h60 + k));
        end
        apply_inputs();
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(1);
            if (o_tx_write != '0) found = 1;
        end
        check("t1_wait_rd_data", found, 1);
        rst = 1'b1;
        #1;
        check("t1_rst_strobes", {o_rx_read, o_tx_write, o_we, o_re}, 0);
        check("t1_rst_buses", {o_addr, o_wdata, o_tx_data}, 0);
        check("t1_rst_empty", o_empty, 10'h3FF);
        check("t1_rst_full", o_full, 10'h000);
        do_reset();
        clear_logs();

        // Single byte on ch3 written to {3,0} and forwarded.
        src[3].push_back(8'hA5);
        apply_inputs();
        step(30);
        check("t2_wr_cnt", wr_log.size(), 1);
        if (wr_log.size() > 0) check("t2_wr", wr_log[0], 16'h0CA5);
        check("t2_rd_cnt", rd_log.size(), 1);
        if (rd_log.size() > 0) check("t2_rd_addr", rd_log[0], 8'h0C);
        check("t2_tx_cnt", tx_log.size(), 1);
        if (tx_log.size() > 0) check("t2_tx", tx_log[0], 16'h03A5);
        check("t2_empty3", o_empty[3], 1);

        // Ch0 fills with the transmitter blocked.
        clear_logs();
        txf[0] = 1'b1;
        for (int b = 0; b < 8; b++) src[0].push_back(8'(8'h10 + b));
        apply_inputs();
        step(120);
`ifdef COLLECTOR_OVERFLOW_DROP_EN
        t3_rxrd = 8; t3_left = 0; t3_tx = 4;
        check("t3_overflow0", o_overflow[0], 1);
`else
        t3_rxrd = 4; t3_left = 4; t3_tx = 8;
`endif
        t3_wr = 4;
        check("t3_wr_cnt", wr_log.size(), t3_wr);
        check("t3_full0", o_full[0], 1);
        check("t3_rxread_cnt", rxrd_cnt[0], t3_rxrd);
        check("t3_src_left", src[0].size(), t3_left);
        clear_logs();
        txf[0] = 1'b0;
        apply_inputs();
        step(250);
        check("t3_tx_cnt", tx_log.size(), t3_tx);
        for (int i = 0; i < t3_tx && i < tx_log.size(); i++)
            check("t3_tx_order", tx_log[i], 16'(16'h0010 + i));
        check("t3_empty0", o_empty[0], 1);

        // Ch1 streams 1..6 through a throttled transmitter; write pointer wraps.
        clear_logs();
        txf[1] = 1'b1;
        for (int b = 1; b <= 4; b++) src[1].push_back(8'(b));
        apply_inputs();
        step(50);
        check("t4_full1", o_full[1], 1);
        txf[1] = 1'b0;
        apply_inputs();
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            step(1);
            if (tx_log.size() >= 2) found = 1;
        end
        check("t4_wait_tx2", found, 1);
        src[1].push_back(8'd5);
        src[1].push_back(8'd6);
        for (int i = 0; i < 20; i++) begin
            txf[1] = ~txf[1];
            apply_inputs();
            step(7);
        end
        txf[1] = 1'b0;
        apply_inputs();
        step(100);
        t4_addr = '{6'd4, 6'd5, 6'd6, 6'd7, 6'd4, 6'd5};
        check("t4_wr_cnt", wr_log.size(), 6);
        for (int i = 0; i < 6 && i < wr_log.size(); i++)
            check("t4_wr_addr", wr_log[i][13:8], t4_addr[i]);
        check("t4_tx_cnt", tx_log.size(), 6);
        for (int i = 0; i < 6 && i < tx_log.size(); i++)
            check("t4_tx_order", tx_log[i], 16'(16'h0100 + i + 1));

        // Ch2 alternates write/read when both are possible on each visit.
        do_reset();
        txf[2] = 1'b1;
        src[2].push_back(8'h21);
        src[2].push_back(8'h22);
        apply_inputs();
        step(30);
        clear_logs();
        for (int b = 3; b <= 6; b++) src[2].push_back(8'(8'h20 + b));
        txf[2] = 1'b0;
        apply_inputs();
        step(150);
        pat = 10'b1110101010;
        check("t5_op_cnt", op_log.size(), 10);
        for (int i = 0; i < 10 && i < op_log.size(); i++)
            check("t5_op_kind", op_log[i], pat[i]);
        check("t5_tx_cnt", tx_log.size(), 6);
        for (int i = 0; i < 6 && i < tx_log.size(); i++)
            check("t5_tx_order", tx_log[i], 16'(16'h0221 + i));

        // Transmitter goes full during the data cycle of an issued read.
        txf[4] = 1'b1;
        src[4].push_back(8'h41);
        src[4].push_back(8'h42);
        apply_inputs();
        step(40);
        clear_logs();
        txf[4] = 1'b0;
        apply_inputs();
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(1);
            if (o_tx_write[4]) begin
                found = 1;
                txf[4] = 1'b1;
                apply_inputs();
            end
        end
        check("t6_wait_rd", found, 1);
        step(40);
        check("t6_tx_cnt_held", tx_log.size(), 1);
        if (tx_log.size() > 0) check("t6_tx0", tx_log[0], 16'h0441);
        check("t6_rd_cnt_held", rd_log.size(), 1);
        txf[4] = 1'b0;
        apply_inputs();
        step(40);
        check("t6_tx_cnt_final", tx_log.size(), 2);
        if (tx_log.size() > 1) check("t6_tx1", tx_log[1], 16'h0442);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
